bju_pred: RTL and testbench

//  Parametrised branch/jump resolution unit for the EX stage. Resolves jal/jalr/br/syscall,

---
 rtl/bju_pkg.sv | 31 +++
 rtl/bht_table.sv | 52 +++++
 rtl/bju_pred.sv | 165 ++++++++++++++++
 tb/tb_bju_pred.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bju_pkg.sv
// Shared types and helpers for the branch/jump resolution unit.
//   br_func3_e  : branch condition encodings carried in func3
//   bht_ctr_t   : 2-bit saturating branch-history counter
//   BHT_WNT     : weakly-not-taken counter value loaded at reset
//   BHT_MAX     : strongly-taken counter value (saturation ceiling)
//   sat_inc/dec : saturating counter update helpers
package bju_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_func3_e;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_WNT = 2'b01;
   localparam bht_ctr_t BHT_MAX = 2'b11;

   function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
      return (c == BHT_MAX) ? c : c + 2'd1;
   endfunction

   function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
      return (c == '0) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters indexed by
// pc[$clog2(BHT_DEPTH)+1:2].
//   clk, rst_n  : clock, synchronous active-low reset (all entries -> BHT_WNT)
//   lkp_pc      : lookup PC from the IFU
//   lkp_taken   : MSB of the indexed counter, combinational
//   upd_en      : apply one counter update this cycle
//   upd_pc      : PC of the resolved branch being trained
//   upd_taken   : resolved direction (increment if 1, decrement if 0)
// A lookup that hits the entry being updated in the same cycle sees the
// value held before the update, since the update lands at the clock edge.
module bht_table
   import bju_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] lkp_pc,
   output logic            lkp_taken,
   input  logic            upd_en,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   bht_ctr_t         ctr [BHT_DEPTH];
   logic [IDX_W-1:0] lkp_idx;
   logic [IDX_W-1:0] upd_idx;

   // Only the index field of the PCs selects an entry.
   logic unused_pc_bits;

   assign lkp_idx = lkp_pc[IDX_W+1:2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{lkp_pc[XLEN-1:IDX_W+2], lkp_pc[1:0],
                             upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            ctr[i] <= BHT_WNT;
         end
      end else if (upd_en) begin
         ctr[upd_idx] <= upd_taken ? sat_inc(ctr[upd_idx]) : sat_dec(ctr[upd_idx]);
      end
   end

   assign lkp_taken = ctr[lkp_idx][1];

endmodule

// File: rtl/bju_pred.sv
// EX-stage branch/jump resolution unit.
// Resolves jal/jalr/br/syscall, compares against the IFU prediction and
// raises a registered redirect only on a mispredict. Owns the BHT the IFU
// reads combinationally and keeps branch / mispredict perf counters.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_vld / in_rdy         : op offered from decode / unit can accept
//   jal, jalr, br, syscall  : op class, one-hot or all zero
//   func3                   : branch condition
//   pc, src1, src2, imm     : operands
//   rcsr                    : trap/return target for syscall
//   pred_taken, pred_pc     : IFU prediction for this op
//   flush                   : kill incoming op and any pending redirect
//   redir_vld/rdy, redir_pc : redirect handshake to IFU, correct next PC
//   res_vld, res_mispred    : one-cycle result pulse, mispredict flag
//   link_val                : pc+4 for the rd write
//   lkp_pc, lkp_taken       : IFU BHT lookup
//   br_cnt, mis_cnt         : resolved-branch / mispredict counts (wrap)
module bju_pred
   import bju_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned BHT_DEPTH = 64,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic             jal,
   input  logic             jalr,
   input  logic             br,
   input  logic             syscall,
   input  logic [2:0]       func3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  src1,
   input  logic [XLEN-1:0]  src2,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rcsr,
   input  logic             pred_taken,
   input  logic [XLEN-1:0]  pred_pc,
   input  logic             flush,
   output logic             redir_vld,
   input  logic             redir_rdy,
   output logic [XLEN-1:0]  redir_pc,
   output logic             res_vld,
   output logic             res_mispred,
   output logic [XLEN-1:0]  link_val,
   input  logic [XLEN-1:0]  lkp_pc,
   output logic             lkp_taken,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mis_cnt
);

   logic            op_any;
   logic            accept;
   logic            br_cond;
   logic            taken;
   logic            mispred;
   logic [XLEN-1:0] link_pc;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] actual_pc;

   // ------------------------------------------------------------------
   // Resolve
   // ------------------------------------------------------------------
   assign op_any = jal | jalr | br | syscall;
   assign in_rdy = ~redir_vld;
   assign accept = in_vld & in_rdy & ~flush & op_any;

   always_comb begin
      br_cond = 1'b0;
      case (br_func3_e'(func3))
         BEQ:     br_cond = (src1 == src2);
         BNE:     br_cond = (src1 != src2);
         BLT:     br_cond = ($signed(src1) <  $signed(src2));
         BGE:     br_cond = ($signed(src1) >= $signed(src2));
         BLTU:    br_cond = (src1 <  src2);
         BGEU:    br_cond = (src1 >= src2);
         default: br_cond = 1'b0;
      endcase
   end

   assign taken    = jal | jalr | syscall | (br & br_cond);
   assign link_pc  = pc + XLEN'(4);
   assign jalr_sum = src1 + imm;

   always_comb begin
      target = pc + imm;
      if (jalr) begin
         target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (syscall) begin
         target = rcsr;
      end
   end

   assign actual_pc = taken ? target : link_pc;
   // A correctly predicted not-taken op has nothing to compare on the target.
   assign mispred   = (taken != pred_taken) | (taken & (target != pred_pc));

   // ------------------------------------------------------------------
   // Result pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_vld     <= 1'b0;
         res_mispred <= 1'b0;
         link_val    <= '0;
      end else begin
         res_vld     <= accept;
         res_mispred <= accept & mispred;
         if (accept) begin
            link_val <= link_pc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Redirect: held stable until handshake or flush. accept is already
   // blocked while pending, so set and clear never coincide.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redir_vld <= 1'b0;
         redir_pc  <= '0;
      end else if (flush) begin
         redir_vld <= 1'b0;
      end else if (redir_vld && redir_rdy) begin
         redir_vld <= 1'b0;
      end else if (accept && mispred) begin
         redir_vld <= 1'b1;
         redir_pc  <= actual_pc;
      end
   end

   // ------------------------------------------------------------------
   // Perf counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else begin
         br_cnt  <= br_cnt  + CNT_W'(accept & br);
         mis_cnt <= mis_cnt + CNT_W'(accept & mispred);
      end
   end

   // ------------------------------------------------------------------
   // Branch history table
   // ------------------------------------------------------------------
   bht_table #(
      .XLEN      (XLEN),
      .BHT_DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .lkp_pc    (lkp_pc),
      .lkp_taken (lkp_taken),
      .upd_en    (accept & br),
      .upd_pc    (pc),
      .upd_taken (br_cond)
   );

endmodule

// File: tb/tb_bju_pred.sv
// Directed + randomised bench for bju_pred with a result scoreboard and a
// reference model of branch resolution, BHT counters and perf counters.
module tb_bju_pred;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned CNTW  = 32;

   logic            clk;
   logic            rst_n;
   logic            in_vld;
   logic            in_rdy;
   logic            jal, jalr, br, syscall;
   logic [2:0]      func3;
   logic [XLEN-1:0] pc, src1, src2, imm, rcsr;
   logic            pred_taken;
   logic [XLEN-1:0] pred_pc;
   logic            flush;
   logic            redir_vld;
   logic            redir_rdy;
   logic [XLEN-1:0] redir_pc;
   logic            res_vld;
   logic            res_mispred;
   logic [XLEN-1:0] link_val;
   logic [XLEN-1:0] lkp_pc;
   logic            lkp_taken;
   logic [CNTW-1:0] br_cnt;
   logic [CNTW-1:0] mis_cnt;

   bju_pred #(
      .XLEN      (XLEN),
      .BHT_DEPTH (DEPTH),
      .CNT_W     (CNTW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_vld      (in_vld),
      .in_rdy      (in_rdy),
      .jal         (jal),
      .jalr        (jalr),
      .br          (br),
      .syscall     (syscall),
      .func3       (func3),
      .pc          (pc),
      .src1        (src1),
      .src2        (src2),
      .imm         (imm),
      .rcsr        (rcsr),
      .pred_taken  (pred_taken),
      .pred_pc     (pred_pc),
      .flush       (flush),
      .redir_vld   (redir_vld),
      .redir_rdy   (redir_rdy),
      .redir_pc    (redir_pc),
      .res_vld     (res_vld),
      .res_mispred (res_mispred),
      .link_val    (link_val),
      .lkp_pc      (lkp_pc),
      .lkp_taken   (lkp_taken),
      .br_cnt      (br_cnt),
      .mis_cnt     (mis_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            mis;
      logic [XLEN-1:0] link;
   } exp_t;

   exp_t            sb[$];
   int              n_assert = 0;
   int              n_fail   = 0;

   // reference model state
   logic [1:0]      m_ctr [DEPTH];
   logic            m_redir;
   logic [XLEN-1:0] m_rpc;
   logic [CNTW-1:0] m_br;
   logic [CNTW-1:0] m_mis;

   localparam logic [3:0] C_JAL  = 4'b1000;
   localparam logic [3:0] C_JALR = 4'b0100;
   localparam logic [3:0] C_BR   = 4'b0010;
   localparam logic [3:0] C_SYS  = 4'b0001;
   localparam logic [3:0] C_NONE = 4'b0000;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_taken(input logic [3:0] cls, input logic [2:0] f3,
                                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic lt_s, lt_u;
      if (cls[3] || cls[2] || cls[0]) return 1'b1;
      if (!cls[1]) return 1'b0;
      lt_u = (a < b);
      // signed compare via sign bits, then magnitude
      lt_s = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : lt_u;
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return lt_s;
         3'd5:    return !lt_s;
         3'd6:    return lt_u;
         3'd7:    return !lt_u;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] m_target(input logic [3:0] cls, input logic [XLEN-1:0] p,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] im,
                                                input logic [XLEN-1:0] rc);
      logic [XLEN-1:0] t;
      if (cls[2]) begin
         t = a + im;
         t[0] = 1'b0;
         return t;
      end
      if (cls[0]) return rc;
      return p + im;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) m_ctr[i] = 2'b01;
      m_redir = 1'b0;
      m_rpc   = '0;
      m_br    = '0;
      m_mis   = '0;
      sb.delete();
   endtask

   // Drive one cycle of stimulus (entered/left at posedge+1).
   task automatic send(input logic [3:0] cls, input logic [2:0] f3,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                       input logic [XLEN-1:0] rc, input logic pt,
                       input logic [XLEN-1:0] ppc, input logic vld, input logic fl);
      logic            acc, tk, mis;
      logic [XLEN-1:0] tgt, act;
      int              idx;
      exp_t            e;
      {jal, jalr, br, syscall} = cls;
      func3 = f3; pc = p; src1 = a; src2 = b; imm = im; rcsr = rc;
      pred_taken = pt; pred_pc = ppc; in_vld = vld; flush = fl; lkp_pc = p;
      acc = vld && !m_redir && !fl && (cls != 4'b0000);
      tk  = m_taken(cls, f3, a, b);
      tgt = m_target(cls, p, a, im, rc);
      act = tk ? tgt : p + 64'd4;
      mis = (tk != pt) || (tk && tgt != ppc);
      idx = int'(p[7:2]);
      #1;
      chk("in_rdy", in_rdy, !m_redir);
      chk("lkp_pre_update", lkp_taken, m_ctr[idx][1]);
      if (acc) begin
         e.mis = mis; e.link = p + 64'd4;
         sb.push_back(e);
         if (cls[1]) begin
            m_br = m_br + 1;
            if (tk) m_ctr[idx] = (m_ctr[idx] == 2'b11) ? 2'b11 : m_ctr[idx] + 2'd1;
            else    m_ctr[idx] = (m_ctr[idx] == 2'b00) ? 2'b00 : m_ctr[idx] - 2'd1;
         end
         if (mis) begin
            m_mis = m_mis + 1;
            m_redir = 1'b1;
            m_rpc = act;
         end
      end
      if (fl) m_redir = 1'b0;
      @(posedge clk);
      #1;
      in_vld = 1'b0; flush = 1'b0;
      {jal, jalr, br, syscall} = 4'b0000;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("res_vld", res_vld, 1'b1);
         chk("res_mispred", res_mispred, e.mis);
         chk("link_val", link_val, e.link);
      end else begin
         chk("res_vld_idle", res_vld, 1'b0);
      end
      chk("redir_vld", redir_vld, m_redir);
      if (m_redir) chk("redir_pc", redir_pc, m_rpc);
      chk("br_cnt", br_cnt, m_br);
      chk("mis_cnt", mis_cnt, m_mis);
   endtask

   task automatic ack();
      redir_rdy = 1'b1;
      @(posedge clk);
      #1;
      redir_rdy = 1'b0;
      m_redir = 1'b0;
      chk("redir_clear", redir_vld, 1'b0);
      chk("in_rdy_after_ack", in_rdy, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      chk("rst_redir_vld", redir_vld, 1'b0);
      chk("rst_redir_pc", redir_pc, '0);
      chk("rst_res_vld", res_vld, 1'b0);
      chk("rst_res_mispred", res_mispred, 1'b0);
      chk("rst_link_val", link_val, '0);
      chk("rst_br_cnt", br_cnt, '0);
      chk("rst_mis_cnt", mis_cnt, '0);
      chk("rst_in_rdy", in_rdy, 1'b1);
      for (int i = 0; i < int'(DEPTH); i++) begin
         lkp_pc = 64'(i) << 2;
         #1;
         chk("rst_bht_sweep", lkp_taken, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   logic [3:0]      r_cls;
   logic [XLEN-1:0] r_p, r_a, r_b, r_im;

   initial begin
      rst_n = 1'b0; in_vld = 1'b0; flush = 1'b0; redir_rdy = 1'b0;
      {jal, jalr, br, syscall} = 4'b0000;
      func3 = '0; pc = '0; src1 = '0; src2 = '0; imm = '0; rcsr = '0;
      pred_taken = 1'b0; pred_pc = '0; lkp_pc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // BHT training: taken bne at 0x100 saturates at 11, then decays to 00
      for (int i = 0; i < 3; i++)
         send(C_BR, 3'd1, 64'h100, 64'd1, 64'd2, 64'h10, '0, 1'b1, 64'h110, 1'b1, 1'b0);
      lkp_pc = 64'h100; #1;
      chk("bht_taken_trained", lkp_taken, 1'b1);
      for (int i = 0; i < 3; i++)
         send(C_BR, 3'd1, 64'h100, 64'd3, 64'd3, 64'h10, '0, 1'b0, 64'h0, 1'b1, 1'b0);
      lkp_pc = 64'h100; #1;
      chk("bht_nt_trained", lkp_taken, 1'b0);
      @(posedge clk); #1;
      do_reset();

      // beq correctly predicted taken
      send(C_BR, 3'd0, 64'h1000, 64'd5, 64'd5, 64'h40, '0, 1'b1, 64'h1040, 1'b1, 1'b0);
      chk("beq_link", link_val, 64'h1004);
      chk("beq_br_cnt", br_cnt, 32'd1);

      // blt mispredicted not-taken; redirect held while IFU stalls
      send(C_BR, 3'd4, 64'h2000, '1, 64'd1, -64'sd8, '0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("blt_redir_pc", redir_pc, 64'h1FF8);
      for (int i = 0; i < 3; i++)
         send(C_JAL, 3'd0, 64'h2400, '0, '0, 64'h8, '0, 1'b1, 64'h2408, 1'b1, 1'b0);
      chk("blt_hold_pc", redir_pc, 64'h1FF8);
      ack();
      chk("blt_mis_cnt", mis_cnt, 32'd1);

      // jalr target has its LSB cleared
      send(C_JALR, 3'd0, 64'h2800, 64'h3001, '0, 64'd4, '0, 1'b1, 64'h3004, 1'b1, 1'b0);
      chk("jalr_ok_redir", redir_vld, 1'b0);
      send(C_JALR, 3'd0, 64'h2800, 64'h3001, '0, 64'd4, '0, 1'b1, 64'h3008, 1'b1, 1'b0);
      chk("jalr_redir_pc", redir_pc, 64'h3004);
      ack();

      // syscall to rcsr, mispredicted
      send(C_SYS, 3'd0, 64'h2C00, '0, '0, '0, 64'h8000, 1'b1, 64'h2C04, 1'b1, 1'b0);
      chk("sys_redir_pc", redir_pc, 64'h8000);
      ack();

      // flush kills an incoming mispredicted op, then a pending redirect
      send(C_JAL, 3'd0, 64'h4000, '0, '0, 64'h20, '0, 1'b0, 64'h0, 1'b1, 1'b1);
      chk("flush_op_dropped", redir_vld, 1'b0);
      send(C_JAL, 3'd0, 64'h4000, '0, '0, 64'h20, '0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("flush_setup_pc", redir_pc, 64'h4020);
      send(C_NONE, 3'd0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      chk("flush_clears_redir", redir_vld, 1'b0);

      // randomised mix including invalid func3, no-op class and flushes
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       r_cls = C_JAL;
            1:       r_cls = C_JALR;
            2:       r_cls = C_SYS;
            3:       r_cls = C_NONE;
            default: r_cls = C_BR;
         endcase
         r_a  = 64'($urandom_range(0, 3)) - 64'd1;
         r_b  = 64'($urandom_range(0, 3)) - 64'd1;
         r_p  = 64'($urandom_range(0, 255)) << 2;
         r_im = 64'($urandom_range(0, 63)) - 64'd32;
         send(r_cls, 3'($urandom_range(0, 7)), r_p, r_a, r_b, r_im, 64'hC000,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? r_p + r_im : r_p + 64'd4,
              1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0));
         if (m_redir) ack();
      end

      // reset while a redirect is pending and the BHT is trained
      send(C_BR, 3'd1, 64'h100, 64'd1, 64'd2, 64'h10, '0, 1'b1, 64'h110, 1'b1, 1'b0);
      send(C_BR, 3'd1, 64'h100, 64'd1, 64'd2, 64'h10, '0, 1'b1, 64'h110, 1'b1, 1'b0);
      send(C_JAL, 3'd0, 64'h5000, '0, '0, 64'h40, '0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("pre_rst_redir", redir_vld, 1'b1);
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
